// File: rtl/pattern_delay_timer_pkg.sv
// Shared types and parameter defaults for the pattern-triggered delay timer.
package pattern_delay_timer_pkg;

    typedef enum logic [3:0] {
        SEARCH = 4'b0001,
        SHIFT  = 4'b0010,
        COUNT  = 4'b0100,
        WAIT   = 4'b1000
    } state_t;

    localparam int         DEF_PAT_LEN     = 4;
    localparam logic [3:0] DEF_PATTERN     = 4'b1101;
    localparam int         DEF_DELAY_W     = 4;
    localparam int         DEF_UNIT_CYCLES = 1000;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pattern_delay_timer_tick.sv
// Reloadable down-counter that marks the last cycle of each delay unit.
module unit_tick_counter
    import pattern_delay_timer_pkg::*;
#(
    parameter int UNIT_CYCLES = DEF_UNIT_CYCLES
) (
    input  logic clk,
    input  logic areset_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int                TICK_W = min_width(UNIT_CYCLES);
    localparam logic [TICK_W-1:0] RELOAD = TICK_W'(UNIT_CYCLES - 1);

    logic [TICK_W-1:0] tick;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            tick <= '0;
        end else if (load) begin
            tick <= RELOAD;
        end else if (en) begin
            tick <= (tick == '0) ? RELOAD : tick - 1'b1;
        end
    end

    assign tc = (tick == '0);

endmodule

// File: rtl/pattern_delay_timer.sv
// Waits for a serial start pattern, captures a delay value, times it out in
// units of UNIT_CYCLES and then holds done until acknowledged.
module pattern_delay_timer
    import pattern_delay_timer_pkg::*;
#(
    parameter int                 PAT_LEN     = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN     = DEF_PATTERN,
    parameter int                 DELAY_W     = DEF_DELAY_W,
    parameter int                 UNIT_CYCLES = DEF_UNIT_CYCLES
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic               d,
    input  logic               ack,
    input  logic               abort,
    output logic               shift_ena,
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] count
);

    localparam int IDX_W  = $clog2(DELAY_W + 1);
    localparam int FILL_W = min_width(PAT_LEN);

    state_t             state;
    logic [PAT_LEN-2:0] hist;
    logic [FILL_W-1:0]  fill;
    logic [DELAY_W-1:0] delay;
    logic [IDX_W-1:0]   idx;
    logic [PAT_LEN-1:0] window;
    logic [DELAY_W:0]   delay_window;
    logic               match;
    logic               last_bit;
    logic               tick_load;
    logic               tick_tc;

    assign window       = {hist, d};
    assign delay_window = {delay, d};
    // fill guards against zeros left in hist completing a pattern early
    assign match        = (window == PATTERN) && (fill == FILL_W'(PAT_LEN - 1));
    assign last_bit     = (idx == IDX_W'(DELAY_W - 1));
    assign tick_load    = (state == SHIFT) && last_bit && !abort;

    unit_tick_counter #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_tick (
        .clk     (clk),
        .areset_n(areset_n),
        .load    (tick_load),
        .en      (state == COUNT),
        .tc      (tick_tc)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= SEARCH;
            hist  <= '0;
            fill  <= '0;
            delay <= '0;
            idx   <= '0;
        end else if (abort) begin
            state <= SEARCH;
            hist  <= '0;
            fill  <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    hist <= window[PAT_LEN-2:0];
                    if (fill != FILL_W'(PAT_LEN - 1)) begin
                        fill <= fill + 1'b1;
                    end
                    if (match) begin
                        state <= SHIFT;
                        idx   <= '0;
                    end
                end
                SHIFT: begin
                    delay <= delay_window[DELAY_W-1:0];
                    idx   <= idx + 1'b1;
                    if (last_bit) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (tick_tc) begin
                        if (delay == '0) begin
                            state <= WAIT;
                        end else begin
                            delay <= delay - 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (ack) begin
                        state <= SEARCH;
                        hist  <= '0;
                        fill  <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign shift_ena = (state == SHIFT);
    assign counting  = (state == COUNT);
    assign done      = (state == WAIT);
    assign count     = (state == COUNT) ? delay : '0;

endmodule

// File: tb/tb_pattern_delay_timer.sv
// Directed bench: one instance at UNIT_CYCLES=4, one with a 6-bit pattern and
// single-cycle units.
module tb_pattern_delay_timer;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       d, ack, abort;
    logic       d2, ack2, abort2;
    logic       shift_ena, counting, done;
    logic [3:0] count;
    logic       shift_ena2, counting2, done2;
    logic [2:0] count2;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    pattern_delay_timer #(
        .PAT_LEN(4), .PATTERN(4'b1101), .DELAY_W(4), .UNIT_CYCLES(4)
    ) dut (
        .clk(clk), .areset_n(areset_n), .d(d), .ack(ack), .abort(abort),
        .shift_ena(shift_ena), .counting(counting), .done(done), .count(count)
    );

    pattern_delay_timer #(
        .PAT_LEN(6), .PATTERN(6'b101100), .DELAY_W(3), .UNIT_CYCLES(1)
    ) dut2 (
        .clk(clk), .areset_n(areset_n), .d(d2), .ack(ack2), .abort(abort2),
        .shift_ena(shift_ena2), .counting(counting2), .done(done2), .count(count2)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_shift_ena"}, 32'(shift_ena), 0);
        check_output({tag, "_counting"}, 32'(counting), 0);
        check_output({tag, "_done"}, 32'(done), 0);
        check_output({tag, "_count"}, 32'(count), 0);
    endtask

    task automatic apply_stimulus(input logic dv, input logic av, input logic bv);
        d     = dv;
        ack   = av;
        abort = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus2(input logic dv);
        d2 = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            apply_stimulus(bits[i], 1'b0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] stale_seq;
        logic [5:0]  pat2;

        areset_n = 1'b0;
        d = 1'b0; ack = 1'b0; abort = 1'b0;
        d2 = 1'b0; ack2 = 1'b0; abort2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check_output("reset_counting2", 32'(counting2), 0);
        check_output("reset_count2", 32'(count2), 0);
        #3 areset_n = 1'b1;

        // Basic run: pattern 1101, delay 0010 -> three units of four cycles.
        send_bits(16'b110, 3);
        check_output("partial_pattern", 32'(shift_ena), 0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("match_shift_ena", 32'(shift_ena), 1);
        send_bits(16'b0, 1);
        check_output("shift_bit1", 32'(shift_ena), 1);
        send_bits(16'b0, 1);
        check_output("shift_bit2", 32'(shift_ena), 1);
        send_bits(16'b1, 1);
        check_output("shift_bit3", 32'(shift_ena), 1);
        send_bits(16'b0, 1);
        check_output("shift_end", 32'(shift_ena), 0);
        for (int i = 0; i < 12; i++) begin
            check_output($sformatf("run_counting_%0d", i), 32'(counting), 1);
            check_output($sformatf("run_count_%0d", i), 32'(count), 32'(2 - i / 4));
            apply_stimulus(1'b0, (i == 5), 1'b0);
        end
        check_output("run_done", 32'(done), 1);
        check_output("run_counting_end", 32'(counting), 0);
        check_output("run_count_end", 32'(count), 0);
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("done_held", 32'(done), 1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_idle("after_ack");

        // Overlapping detection: 11101 matches on the fifth bit; delay 0.
        send_bits(16'b1110, 4);
        check_output("overlap_no_early", 32'(shift_ena), 0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("overlap_match", 32'(shift_ena), 1);
        send_bits(16'b0000, 4);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("zero_counting_%0d", i), 32'(counting), 1);
            check_output($sformatf("zero_count_%0d", i), 32'(count), 0);
            apply_stimulus(1'b0, 1'b0, 1'b0);
        end
        check_output("zero_done", 32'(done), 1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_idle("zero_after_ack");

        // Abort mid-count; stale history must not complete a pattern afterwards.
        send_bits(16'b1101, 4);
        send_bits(16'b0001, 4);
        check_output("pre_abort_count", 32'(count), 1);
        repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("pre_abort_counting", 32'(counting), 1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_idle("abort");
        stale_seq = 16'b1011101;
        for (int i = 6; i >= 1; i--) begin
            apply_stimulus(stale_seq[i], 1'b0, 1'b0);
            check_output($sformatf("stale_no_match_%0d", i), 32'(shift_ena), 0);
        end
        apply_stimulus(stale_seq[0], 1'b0, 1'b0);
        check_output("recover_after_abort", 32'(shift_ena), 1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_idle("abort_in_shift");

        // Asynchronous reset between edges during SHIFT.
        send_bits(16'b1101, 4);
        send_bits(16'b01, 2);
        check_output("pre_reset_shift", 32'(shift_ena), 1);
        #2 areset_n = 1'b0;
        #1;
        check_idle("async_reset");
        #1 areset_n = 1'b1;
        send_bits(16'b1101, 4);
        check_output("reset_recover_match", 32'(shift_ena), 1);
        send_bits(16'b0000, 4);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0);
        end
        check_output("reset_recover_done", 32'(done), 1);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_idle("ack_abort");

        // Six-bit pattern, three-bit delay of 7, one cycle per unit.
        pat2 = 6'b101100;
        for (int i = 5; i >= 0; i--) begin
            apply_stimulus2(pat2[i]);
        end
        check_output("p6_match", 32'(shift_ena2), 1);
        repeat (3) apply_stimulus2(1'b1);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("p6_counting_%0d", i), 32'(counting2), 1);
            check_output($sformatf("p6_count_%0d", i), 32'(count2), 32'(7 - i));
            apply_stimulus2(1'b0);
        end
        check_output("p6_done", 32'(done2), 1);
        check_output("p6_counting_end", 32'(counting2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_delay_timer.md
PATTERN_DELAY_TIMER -- requirements
Module: pattern_delay_timer

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4, meaning start-pattern length in bits (>=2).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1101 (PAT_LEN bits), meaning the start pattern, MSB received first.
REQ-003 The block SHALL have parameter DELAY_W, default 4, meaning delay-field width in bits (>=1).
REQ-004 The block SHALL have parameter UNIT_CYCLES, default 1000, meaning clock cycles per delay unit (>=1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, all flops rising-edge.
REQ-006 The block SHALL have port areset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port d, input, 1 bit: serial data, sampled every cycle.
REQ-008 The block SHALL have port ack, input, 1 bit: user acknowledge of done.
REQ-009 The block SHALL have port abort, input, 1 bit: cancels any operation in progress.
REQ-010 The block SHALL have port shift_ena, output, 1 bit: high while delay bits are captured.
REQ-011 The block SHALL have port counting, output, 1 bit: high while the timer runs.
REQ-012 The block SHALL have port done, output, 1 bit: high while waiting for ack.
REQ-013 The block SHALL have port count, output, DELAY_W bits: remaining delay units; zero outside COUNT.

Function
REQ-014 The FSM SHALL have four states: SEARCH, SHIFT, COUNT, WAIT; all outputs are Moore and registered-state-derived only.
REQ-015 SEARCH: hist (PAT_LEN-1 bits) shifts in d each cycle; when {hist,d}==PATTERN, next state is SHIFT; overlapping matches are detected (1101 found inside 11101).
REQ-016 hist SHALL clear to 0 on every entry to SEARCH; a match needs PAT_LEN fresh bits received in SEARCH.
REQ-017 SHIFT: shift_ena=1 for exactly DELAY_W cycles; each cycle, delay <= {delay[DELAY_W-2:0], d} (MSB first); after the DELAY_W-th bit, next state is COUNT.
REQ-018 COUNT: counting=1; tick counter loads UNIT_CYCLES-1 on entry and decrements each cycle; at 0, the counter reloads and delay decrements.
REQ-019 COUNT SHALL exit to WAIT on the cycle where tick==0 and delay==0; total COUNT dwell is exactly (delay+1)*UNIT_CYCLES cycles.
REQ-020 count SHALL equal the delay register during COUNT: it starts at the captured value and decrements at each unit boundary.
REQ-021 WAIT: done=1; ack high moves the FSM to SEARCH next cycle; ack is ignored in all other states.
REQ-022 abort high in any state SHALL move the FSM to SEARCH next cycle; abort has priority over ack, match and count expiry.
REQ-023 shift_ena, counting and done SHALL be mutually exclusive; all three are 0 in SEARCH.
REQ-024 Arithmetic: the tick counter is $clog2(UNIT_CYCLES) bits (min 1); delay decrement never wraps below 0.
REQ-025 UNIT_CYCLES=1: each COUNT cycle is one unit boundary.

Reset
REQ-026 While areset_n=0, state SHALL be SEARCH, and hist, delay and tick SHALL be 0, independent of clk.
REQ-027 Reset outputs SHALL be shift_ena=0, counting=0, done=0, count=0.
REQ-028 Reset mid-operation SHALL discard all progress, and detection restarts on the first edge after release.

Structure
REQ-029 A shared package pattern_delay_timer_pkg SHALL hold the state typedef (SEARCH, SHIFT, COUNT, WAIT, one-hot encoded) and parameter defaults.
REQ-030 The design SHALL contain one sub-module, unit_tick_counter: a reloadable down-counter with a load/enable input and a tc (terminal count) output, parameterised by UNIT_CYCLES.
REQ-031 The SHIFT bit-index counter SHALL be $clog2(DELAY_W+1) bits.

Verification (UNIT_CYCLES=4 unless stated)
REQ-032 d=1,1,0,1 then 0,0,1,0 -> shift_ena high 4 cycles; counting high 12 cycles; count =2,1,0 for 4 cycles each; then done=1 held until ack.
REQ-033 d=1,1,1,0,1 -> match on the 5th bit (overlap); delay 0000 -> counting exactly 4 cycles.
REQ-034 abort asserted mid-COUNT -> SEARCH next cycle with counting=0; a new pattern is required, and stale hist bits SHALL NOT match.
REQ-035 areset_n pulsed low mid-SHIFT, asynchronously between edges -> outputs immediately 0; recovery on a new pattern.
REQ-036 ack high during COUNT is ignored; in WAIT, ack and abort together -> SEARCH.
REQ-037 With PAT_LEN=6, PATTERN=6'b101100, DELAY_W=3, UNIT_CYCLES=1, delay 111 -> counting exactly 8 cycles.
